// File: rtl/cpu_vga_plotter.sv
// Command FIFO + pixel engine feeding the VGA adapter plot port, one pixel per clock.
// Optional full-screen clear (op 10) is built only when VGA_PLOT_CLEAR_EN is defined.
module cpu_vga_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int LEN_W    = 8,
    parameter int DEPTH    = 8,
    parameter int H_RES    = 160,
    parameter int V_RES    = 120
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [X_W-1:0]            cmd_x,
    input  logic [Y_W-1:0]            cmd_y,
    input  logic [LEN_W-1:0]          cmd_len,
    input  logic [COLOUR_W-1:0]       cmd_colour,
    output logic [X_W-1:0]            vga_x,
    output logic [Y_W-1:0]            vga_y,
    output logic [COLOUR_W-1:0]       vga_colour,
    output logic                      vga_plot,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      dropped
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = ((X_W > LEN_W) ? X_W : LEN_W) + 1;
    localparam int YW1 = Y_W + 1;
    localparam int FW  = 2 + X_W + Y_W + LEN_W + COLOUR_W;
    localparam logic [LW-1:0]  DEPTH_C = LW'(DEPTH);
    localparam logic [CW-1:0]  HRES_C  = CW'(H_RES);
    localparam logic [YW1-1:0] VRES_C  = YW1'(V_RES);
`ifdef VGA_PLOT_CLEAR_EN
    localparam logic [X_W-1:0] XMAX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] YMAX = Y_W'(V_RES - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_PIX, S_LINE, S_CLEAR} state_t;

    logic [FW-1:0]       r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]       r_level;
    state_t              r_state;
    logic [CW-1:0]       r_rem;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot, r_dropped;

    logic                w_full, w_empty, w_push, w_pop, w_last;
    logic [1:0]          w_op;
    logic [X_W-1:0]      w_hx;
    logic [Y_W-1:0]      w_hy;
    logic [LEN_W-1:0]    w_hlen;
    logic [COLOUR_W-1:0] w_hcol;
    logic [CW-1:0]       w_x_ext, w_end, w_len_eff;
    logic                w_x_oob, w_y_oob;

    assign w_full    = (r_level == DEPTH_C);
    assign w_empty   = (r_level == '0);
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = w_last && !w_empty;
    assign cmd_ready = !w_full;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {cmd_op, cmd_x, cmd_y, cmd_len, cmd_colour};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Head-of-queue decode and clipping; the extra counter bit keeps x+len from wrapping.
    assign {w_op, w_hx, w_hy, w_hlen, w_hcol} = r_mem[r_rd_ptr];
    assign w_x_ext   = CW'(w_hx);
    assign w_end     = w_x_ext + CW'(w_hlen);
    assign w_len_eff = (w_end > HRES_C) ? (HRES_C - w_x_ext) : CW'(w_hlen);
    assign w_x_oob   = (w_x_ext >= HRES_C);
    assign w_y_oob   = ({1'b0, w_hy} >= VRES_C);

    // The current command ends this cycle, so the next one may be popped on this edge.
    always_comb begin
        w_last = 1'b1;
        case (r_state)
            S_LINE:  w_last = (r_rem == '0);
`ifdef VGA_PLOT_CLEAR_EN
            S_CLEAR: w_last = (r_x == XMAX) && (r_y == YMAX);
`endif
            default: w_last = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= '0;
            r_plot    <= 1'b0;
            r_dropped <= 1'b0;
        end else if (w_pop) begin
            r_plot  <= 1'b0;
            r_state <= S_IDLE;
            r_rem   <= '0;
            case (w_op)
                2'b00: begin
                    if (w_x_oob || w_y_oob) begin
                        r_dropped <= 1'b1;
                    end else begin
                        r_x      <= w_hx;
                        r_y      <= w_hy;
                        r_colour <= w_hcol;
                        r_plot   <= 1'b1;
                        r_state  <= S_PIX;
                    end
                end
                2'b01: begin
                    if (w_x_oob || w_y_oob) begin
                        r_dropped <= 1'b1;
                    end else if (w_hlen != '0) begin
                        r_x      <= w_hx;
                        r_y      <= w_hy;
                        r_colour <= w_hcol;
                        r_plot   <= 1'b1;
                        r_rem    <= w_len_eff - 1'b1;
                        r_state  <= S_LINE;
                    end
                end
`ifdef VGA_PLOT_CLEAR_EN
                2'b10: begin
                    r_x      <= '0;
                    r_y      <= '0;
                    r_colour <= w_hcol;
                    r_plot   <= 1'b1;
                    r_state  <= S_CLEAR;
                end
`endif
                default: ;
            endcase
        end else if (w_last) begin
            r_plot  <= 1'b0;
            r_state <= S_IDLE;
        end else begin
            if (r_state == S_LINE) begin
                r_x   <= r_x + 1'b1;
                r_rem <= r_rem - 1'b1;
            end
`ifdef VGA_PLOT_CLEAR_EN
            else if (r_state == S_CLEAR) begin
                if (r_x == XMAX) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
`endif
        end
    end

    assign vga_x      = r_x;
    assign vga_y      = r_y;
    assign vga_colour = r_colour;
    assign vga_plot   = r_plot;
    assign dropped    = r_dropped;
    assign fifo_level = r_level;
    assign busy       = (r_state != S_IDLE) || (r_level != '0);
endmodule

// File: tb/tb_cpu_vga_plotter.sv
// Directed bench for cpu_vga_plotter at default parameters; strobes are logged on the falling edge.
module tb_cpu_vga_plotter;
    logic       clk = 0, reset = 0;
    logic       cmd_valid = 0, cmd_ready;
    logic [1:0] cmd_op = 0;
    logic [7:0] cmd_x = 0;
    logic [6:0] cmd_y = 0;
    logic [7:0] cmd_len = 0;
    logic [2:0] cmd_colour = 0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, dropped;
    logic [3:0] fifo_level;

    int n_vec = 0, n_err = 0;
    int cyc = 0;

    typedef struct { int x; int y; int c; int t; } strobe_t;
    strobe_t q[$];

    cpu_vga_plotter dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_len(cmd_len),
        .cmd_colour(cmd_colour), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .fifo_level(fifo_level), .dropped(dropped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        strobe_t s;
        if (vga_plot === 1'b1) begin
            s.x = int'(vga_x); s.y = int'(vga_y); s.c = int'(vga_colour); s.t = cyc;
            q.push_back(s);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [1:0] op, input int x, input int y, input int len, input int col);
        cmd_valid = 1'b1; cmd_op = op; cmd_x = 8'(x); cmd_y = 7'(y);
        cmd_len = 8'(len); cmd_colour = 3'(col);
    endtask

    // Holds the command until accepted (bounded), then drops cmd_valid.
    task automatic push(input logic [1:0] op, input int x, input int y, input int len, input int col);
        drive(op, x, y, len, col);
        for (int k = 0; k < 400 && !cmd_ready; k++) step();
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy; k++) step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step();
        n_vec++; if (vga_plot !== 1'b0) begin n_err++; $display("FAIL rst_plot got %0b want 0", vga_plot); end
        n_vec++; if ({vga_x, vga_y, vga_colour} !== 18'd0) begin n_err++; $display("FAIL rst_xyc got %0d,%0d,%0d want 0,0,0", vga_x, vga_y, vga_colour); end
        n_vec++; if (fifo_level !== 4'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_lvl_busy got %0d,%0b want 0,0", fifo_level, busy); end
        n_vec++; if (cmd_ready !== 1'b1 || dropped !== 1'b0) begin n_err++; $display("FAIL rst_rdy_drop got %0b,%0b want 1,0", cmd_ready, dropped); end
        reset = 1'b0; step();
    endtask

    task automatic test_pixel();
        q.delete();
        drive(2'b00, 5, 7, 0, 3);
        step();                       // E0: push
        cmd_valid = 1'b0;
        n_vec++; if (vga_plot !== 1'b0) begin n_err++; $display("FAIL pix_early got %0b want 0", vga_plot); end
        step();                       // E1: pop, strobe registered
        n_vec++; if (vga_plot !== 1'b1 || vga_x !== 8'd5 || vga_y !== 7'd7 || vga_colour !== 3'd3) begin
            n_err++; $display("FAIL pix_strobe got plot=%0b x=%0d y=%0d c=%0d want 1,5,7,3", vga_plot, vga_x, vga_y, vga_colour); end
        step();
        n_vec++; if (vga_plot !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL pix_end got plot=%0b busy=%0b want 0,0", vga_plot, busy); end
        n_vec++; if (vga_x !== 8'd5 || vga_y !== 7'd7) begin n_err++; $display("FAIL pix_hold got %0d,%0d want 5,7", vga_x, vga_y); end
        step();
        n_vec++; if (q.size() !== 1) begin n_err++; $display("FAIL pix_count got %0d want 1", q.size()); end
    endtask

    task automatic test_hline_clip();
        int bad = 0;
        q.delete();
        push(2'b01, 150, 10, 20, 6);
        wait_idle(100);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL hl_timeout busy=%0b want 0", busy); end
        n_vec++; if (q.size() !== 10) begin n_err++; $display("FAIL hl_count got %0d want 10", q.size()); end
        foreach (q[i]) if (q[i].x != 150 + i || q[i].y != 10 || q[i].c != 6 || q[i].t != q[0].t + i) bad++;
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL hl_pixels got %0d bad want 0", bad); end
        n_vec++; if (dropped !== 1'b0) begin n_err++; $display("FAIL hl_dropped got %0b want 0", dropped); end
        // zero-length line is a silent nop
        q.delete();
        push(2'b01, 3, 3, 0, 1);
        wait_idle(20);
        n_vec++; if (q.size() !== 0 || dropped !== 1'b0) begin n_err++; $display("FAIL hl_len0 got %0d strobes drop=%0b want 0,0", q.size(), dropped); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        q.delete();
        push(2'b01, 0, 20, 200, 2);   // clipped to 160 pixels
        step(); step();
        for (int i = 0; i < 8; i++) push(2'b00, 10 + i, 30, 0, i);
        n_vec++; if (fifo_level !== 4'd8 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full got lvl=%0d rdy=%0b want 8,0", fifo_level, cmd_ready); end
        for (int i = 8; i < 10; i++) push(2'b00, 10 + i, 30, 0, i);
        wait_idle(400);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_timeout busy=%0b want 0", busy); end
        n_vec++; if (q.size() !== 170) begin n_err++; $display("FAIL b2b_count got %0d want 170", q.size()); end
        foreach (q[i]) begin
            if (i < 160) begin
                if (q[i].x != i || q[i].y != 20 || q[i].c != 2) bad++;
            end else if (q[i].x != i - 150 || q[i].y != 30 || q[i].c != ((i - 160) & 7)) bad++;
            if (q[i].t != q[0].t + i) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL b2b_order got %0d bad want 0", bad); end
    endtask

    task automatic test_drop();
        q.delete();
        push(2'b00, 159, 119, 0, 5);  // corner pixel, in range
        wait_idle(20);
        n_vec++; if (q.size() !== 1 || dropped !== 1'b0) begin n_err++; $display("FAIL drop_corner got %0d strobes drop=%0b want 1,0", q.size(), dropped); end
        q.delete();
        push(2'b00, 200, 0, 0, 1);
        wait_idle(20);
        n_vec++; if (q.size() !== 0 || dropped !== 1'b1) begin n_err++; $display("FAIL drop_pix got %0d strobes drop=%0b want 0,1", q.size(), dropped); end
        push(2'b01, 0, 120, 5, 1);    // row out of range
        push(2'b00, 1, 1, 0, 4);
        push(2'b11, 0, 0, 0, 0);
        wait_idle(20);
        n_vec++; if (q.size() !== 1 || dropped !== 1'b1) begin n_err++; $display("FAIL drop_sticky got %0d strobes drop=%0b want 1,1", q.size(), dropped); end
    endtask

    task automatic test_clear();
        q.delete();
        push(2'b10, 7, 7, 0, 0);
        wait_idle(20000);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_timeout busy=%0b want 0", busy); end
`ifdef VGA_PLOT_CLEAR_EN
        n_vec++; if (q.size() !== 19200) begin n_err++; $display("FAIL clr_count got %0d want 19200", q.size()); end
        if (q.size() == 19200) begin
            n_vec++; if (q[0].x != 0 || q[0].y != 0 || q[19199].x != 159 || q[19199].y != 119 || q[19199].t != q[0].t + 19199) begin
                n_err++; $display("FAIL clr_span got (%0d,%0d)..(%0d,%0d) span %0d want (0,0)..(159,119) span 19199",
                                  q[0].x, q[0].y, q[19199].x, q[19199].y, q[19199].t - q[0].t); end
        end
`else
        n_vec++; if (q.size() !== 0) begin n_err++; $display("FAIL clr_nop got %0d strobes want 0", q.size()); end
`endif
    endtask

    task automatic test_reset_mid();
        q.delete();
`ifdef VGA_PLOT_CLEAR_EN
        push(2'b10, 0, 0, 0, 1);
`else
        push(2'b01, 0, 40, 160, 1);
`endif
        for (int i = 0; i < 3; i++) push(2'b00, i, 1, 0, 2);
        step(); step();
        n_vec++; if (fifo_level !== 4'd3 || vga_plot !== 1'b1) begin n_err++; $display("FAIL mid_pre got lvl=%0d plot=%0b want 3,1", fifo_level, vga_plot); end
        reset = 1'b1; #1;
        n_vec++; if (vga_plot !== 1'b0 || fifo_level !== 4'd0 || busy !== 1'b0 || dropped !== 1'b0) begin
            n_err++; $display("FAIL mid_rst got plot=%0b lvl=%0d busy=%0b drop=%0b want 0,0,0,0", vga_plot, fifo_level, busy, dropped); end
        step(); reset = 1'b0;
        q.delete();
        for (int k = 0; k < 20; k++) step();
        n_vec++; if (q.size() !== 0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_after got %0d strobes busy=%0b want 0,0", q.size(), busy); end
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_hline_clip();
        test_back_to_back();
        test_drop();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
